// File: rtl/text_exp_pkg.sv
// text_exp_pkg: shared definitions for the text stream expander.
//   - CHAR_BASE / CODE_SPACE / CODE_NL: fixed points of the code-to-ASCII map
//   - exp_state_t: decoder state (S_CODE = expecting a code, S_LIT = expecting a literal)
//   - expand_code(): maps a non-escape code to its char and a reserved-code flag
package text_exp_pkg;

    localparam logic [7:0] CHAR_BASE  = 8'h21;
    localparam int         CODE_SPACE = 94;
    localparam int         CODE_NL    = 95;

    typedef enum logic {S_CODE, S_LIT} exp_state_t;

    typedef struct packed {
        logic [7:0] ch;
        logic       is_err;
    } expand_t;

    // Escape is decided by the caller; anything above CODE_NL reaching here is reserved.
    function automatic expand_t expand_code(input logic [7:0] code, input logic [7:0] unk_char);
        expand_t r;
        r.ch     = unk_char;
        r.is_err = 1'b1;
        if (code <= 8'd93) begin
            r.ch     = CHAR_BASE + code;
            r.is_err = 1'b0;
        end else if (code == CODE_SPACE[7:0]) begin
            r.ch     = 8'h20;
            r.is_err = 1'b0;
        end else if (code == CODE_NL[7:0]) begin
            r.ch     = 8'h0A;
            r.is_err = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/text_bit_unpacker.sv
// text_bit_unpacker: MSB-aligned bit buffer that turns IN_W-bit words into a bit stream.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/in_valid/in_ready/in_last   word input (bit IN_W-1 first), frame end marker
//   lit                 1: consumer wants 8 bits, 0: CODE_W bits
//   pop_en              consumer can take bits this cycle
//   pop                 bits are consumed this cycle
//   bits                top 8 buffered bits (stream order, MSB first)
//   frame_end           last frame bits are too few to form a unit; they are discarded now
module text_bit_unpacker
    import text_exp_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int CODE_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic            lit,
    input  logic            pop_en,
    output logic            pop,
    output logic [7:0]      bits,
    output logic            frame_end
);

    localparam int ACC_W = IN_W + 8;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] ROOM = CNT_W'(ACC_W - IN_W);
    localparam logic [CNT_W-1:0] IN_N = CNT_W'(IN_W);

    // Valid bits live at the top of acc_q; everything below cnt_q is kept zero
    // so new words can simply be OR-ed in.
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, need, popped, cnt_left;
    logic             last_seen;
    logic             accept;

    assign need      = lit ? CNT_W'(8) : CNT_W'(CODE_W);
    assign in_ready  = !rst && !last_seen && (cnt_q <= ROOM);
    assign accept    = in_valid && in_ready;
    assign pop       = pop_en && (cnt_q >= need);
    assign frame_end = last_seen && (cnt_q < need) && !accept;
    assign bits      = acc_q[ACC_W-1 -: 8];

    always_comb begin
        popped   = pop ? need : '0;
        cnt_left = cnt_q - popped;
        acc_d    = acc_q << popped;
        cnt_d    = cnt_left;
        if (accept) begin
            // Land the new word right below whatever survives this cycle's pop.
            acc_d = acc_d | ({in_data, 8'h00} >> cnt_left);
            cnt_d = cnt_left + IN_N;
        end
        if (frame_end) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            last_seen <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (accept && in_last)
                last_seen <= 1'b1;
            else if (frame_end)
                last_seen <= 1'b0;
        end
    end

endmodule

// File: rtl/text_stream_expander.sv
// text_stream_expander: unpacks CODE_W-bit codes from a packed word stream and expands
// each to an 8-bit ASCII char; an escape code introduces a raw 8-bit literal.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_data/in_valid/in_ready/in_last  packed input words, in_last marks frame end
//   out_char/out_valid/out_ready    single-register char output slot
//   frame_done                      pulse when a frame's last bits are consumed/discarded
//   code_err                        pulse on reserved code or truncated literal
//   char_count, err_count           (only with TEXT_EXP_STATS_EN) saturating counters
// Optional feature macro: TEXT_EXP_STATS_EN.
module text_stream_expander
    import text_exp_pkg::*;
#(
    parameter int         CODE_W   = 7,
    parameter int         IN_W     = 8,
    parameter int         ESC_CODE = (1 << CODE_W) - 1,
    parameter logic [7:0] UNK_CHAR = 8'h3F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    output logic [7:0]      out_char,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            frame_done,
    output logic            code_err
`ifdef TEXT_EXP_STATS_EN
    ,
    output logic [15:0]     char_count,
    output logic [15:0]     err_count
`endif
);

    localparam logic [CODE_W-1:0] ESC = ESC_CODE[CODE_W-1:0];

    exp_state_t        state, state_next;
    logic              pop, frame_end;
    logic [7:0]        bits;
    logic [CODE_W-1:0] code;
    expand_t           exp_res;
    logic              emit, err_next, done_next;
    logic [7:0]        char_next;

    text_bit_unpacker #(
        .IN_W   (IN_W),
        .CODE_W (CODE_W)
    ) u_unpack (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .lit       (state == S_LIT),
        .pop_en    (!out_valid || out_ready),
        .pop       (pop),
        .bits      (bits),
        .frame_end (frame_end)
    );

    assign code    = bits[7 -: CODE_W];
    assign exp_res = expand_code(8'(code), UNK_CHAR);

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        char_next  = out_char;
        err_next   = 1'b0;
        done_next  = 1'b0;
        if (pop) begin
            if (state == S_LIT) begin
                emit       = 1'b1;
                char_next  = bits;
                state_next = S_CODE;
            end else if (code == ESC) begin
                state_next = S_LIT;
            end else begin
                emit      = 1'b1;
                char_next = exp_res.ch;
                err_next  = exp_res.is_err;
            end
        end
        // Frame end never coincides with a pop (cnt < need), so no overlap with the above.
        if (frame_end) begin
            done_next = 1'b1;
            if (state == S_LIT) begin
                err_next   = 1'b1;
                state_next = S_CODE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CODE;
            out_char   <= 8'h00;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= done_next;
            code_err   <= err_next;
            if (emit) begin
                out_char  <= char_next;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef TEXT_EXP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            char_count <= '0;
            err_count  <= '0;
        end else begin
            if (out_valid && out_ready && char_count != 16'hFFFF)
                char_count <= char_count + 16'd1;
            if (code_err && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_text_stream_expander.sv
// tb_text_stream_expander: directed test of text_stream_expander (default parameters).
module tb_text_stream_expander;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic       frame_done;
    logic       code_err;
`ifdef TEXT_EXP_STATS_EN
    logic [15:0] char_count;
    logic [15:0] err_count;
`endif

    int total = 0;
    int bad   = 0;
    int n_done;
    int n_err;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    text_stream_expander dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .out_char   (out_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .code_err   (code_err)
`ifdef TEXT_EXP_STATS_EN
        ,
        .char_count (char_count),
        .err_count  (err_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record this cycle's handshake and flag pulses, then step to 1 after the edge.
    task automatic tick();
        if (out_valid && out_ready) got.push_back(out_char);
        if (frame_done === 1'b1) n_done++;
        if (code_err === 1'b1) n_err++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        got.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic send(input logic [7:0] w, input logic l);
        int n;
        in_data  = w;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL send_timeout: in_ready stuck low, word=%0h", w);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_char", out_char, 8'h00);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_code_err", code_err, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Basic: 'A','B', two pad bits dropped
        clr();
        send(8'h40, 1'b0);
        chk("basic_latency_none", out_valid, 0);
        send(8'h84, 1'b1);
        chk("basic_first_valid", out_valid, 1);
        chk("basic_first_char", out_char, 8'h41);
        idle(6);
        chk("basic_count", got.size(), 2);
        chk("basic_c0", got[0], 8'h41);
        chk("basic_c1", got[1], 8'h42);
        chk("basic_done", n_done, 1);
        chk("basic_err", n_err, 0);
        chk("basic_ready_again", in_ready, 1);

        // Escape literal 0x80
        clr();
        send(8'hFF, 1'b0);
        send(8'h00, 1'b1);
        idle(6);
        chk("esc_count", got.size(), 1);
        chk("esc_c0", got[0], 8'h80);
        chk("esc_done", n_done, 1);
        chk("esc_err", n_err, 0);

        // Reserved code 100
        clr();
        send(8'hC8, 1'b1);
        idle(6);
        chk("rsv_count", got.size(), 1);
        chk("rsv_c0", got[0], 8'h3F);
        chk("rsv_err", n_err, 1);
        chk("rsv_done", n_done, 1);

        // Backpressure: 'H','i',' ','!'
        clr();
        out_ready = 1'b0;
        send(8'h4F, 1'b0);
        send(8'h22, 1'b0);
        idle(3);
        chk("bp_in_ready_low", in_ready, 0);
        idle(3);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_char", out_char, 8'h48);
        chk("bp_in_ready_still_low", in_ready, 0);
        chk("bp_no_handshake", got.size(), 0);
        out_ready = 1'b1;
        send(8'hF0, 1'b0);
        send(8'h00, 1'b1);
        idle(8);
        chk("bp_count", got.size(), 4);
        chk("bp_c0", got[0], 8'h48);
        chk("bp_c1", got[1], 8'h69);
        chk("bp_c2", got[2], 8'h20);
        chk("bp_c3", got[3], 8'h21);
        chk("bp_done", n_done, 1);

        // Truncated literal: ESC + 1 bit
        clr();
        send(8'hFE, 1'b1);
        idle(6);
        chk("trunc_count", got.size(), 0);
        chk("trunc_err", n_err, 1);
        chk("trunc_done", n_done, 1);
        clr();
        send(8'h40, 1'b0);
        send(8'h84, 1'b1);
        idle(6);
        chk("trunc_after_count", got.size(), 2);
        chk("trunc_after_c0", got[0], 8'h41);
        chk("trunc_after_c1", got[1], 8'h42);

        // Reset mid-frame with a held char and buffered bits
        clr();
        out_ready = 1'b0;
        send(8'h40, 1'b0);
        send(8'h84, 1'b0);
        idle(1);
        chk("mid_held_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        clr();
        send(8'h40, 1'b0);
        send(8'h84, 1'b1);
        idle(6);
        chk("mid_count", got.size(), 2);
        chk("mid_c0", got[0], 8'h41);
        chk("mid_c1", got[1], 8'h42);
        chk("mid_done", n_done, 1);
        chk("mid_err", n_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
